reg_bank_alu: RTL and testbench
===============================

Name: reg_bank_alu

Overview:
- Parametrised successor to the single 8-bit A register: a bank of NUM_REGS registers of WIDTH bits on the shared CPU bus.
- Each register supports load-from-bus, clear, increment, decrement, shift left/right and register-to-register move.
- Registered zero/carry flags feed the control unit for conditional jumps.
- Sits between the bus and the ALU; one write and one read select per cycle.

Parameters:
- WIDTH, 8, register and bus width in bits (>=2).
- NUM_REGS, 4, number of registers in the bank (>=1).
- SEL_W, clog2(NUM_REGS) (min 1), select width; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- op  input  3  operation code, applied to register wr_sel at the clock edge.
- wr_sel  input  SEL_W  destination register index.
- rd_sel  input  SEL_W  source index for the bus output and for the MOV operation.
- enable  input  1  output enable; drives reg[rd_sel] onto bus_out.
- data_in_bus  input  WIDTH  bus data for LOAD.
- bus_out  output  WIDTH  register read data.
- zero_flag  output  1  registered zero flag.
- carry_flag  output  1  registered carry/borrow flag.

Behaviour:
- Reset (rst=0, async): all registers, zero_flag and carry_flag go to 0 immediately. Ops are ignored while rst=0. Reset mid-operation discards the pending op.
- Ops, each taking effect at the rising clk edge with 1-cycle latency to register and flags:
  - 0 NOP: no change; flags hold.
  - 1 LOAD: reg[wr_sel] <= data_in_bus; carry <= 0.
  - 2 CLR: reg[wr_sel] <= 0; carry <= 0.
  - 3 INC: reg <= reg+1 mod 2^WIDTH; carry <= 1 only on wrap from all-ones to 0.
  - 4 DEC: reg <= reg-1 mod 2^WIDTH; carry <= 1 only on borrow, i.e. wrap from 0 to all-ones.
  - 5 SHL: reg <= {reg[WIDTH-2:0],0}; carry <= old MSB.
  - 6 SHR: reg <= {0,reg[WIDTH-1:1]} (logical); carry <= old LSB.
  - 7 MOV: reg[wr_sel] <= reg[rd_sel] (pre-edge value); carry <= 0.
- zero_flag <= (new value of reg[wr_sel] == 0) for every op except NOP.
- Read path: bus_out is combinational from current (pre-edge) contents of reg[rd_sel] when enable=1, else 0 (see optional feature).
  - Simultaneous write and read of the same index: bus_out shows the old value until the edge, then the new value.
- MOV with wr_sel==rd_sel: register unchanged; flags still updated (carry=0, zero from value).
- Out-of-range select (index >= NUM_REGS, non-power-of-2 banks):
  - Write with out-of-range wr_sel is dropped, and flags hold.
  - Out-of-range rd_sel reads as 0, including as the MOV source.
- Only one register changes per cycle; all others hold.

Optional Feature:
- Macro TRISTATE_BUS_EN.
- Defined: bus_out is a tri-state driver: reg[rd_sel] when enable=1, high-impedance (all Z) when enable=0, for direct connection to the shared SAP bus wire.
- Undefined: bus_out drives 0 when enable=0, for OR-muxed bus integration. Undefined is the default.

Test Plan:
- Async reset: load reg0=8'h5A, then pulse rst=0 mid-cycle -> reg0=0, zero_flag=0, carry_flag=0 before the next edge; bus_out (enable=1, rd_sel=0) = 8'h00.
- LOAD/read: data_in_bus=8'h0F, op=LOAD, wr_sel=2 -> next cycle, rd_sel=2 with enable=1 gives bus_out=8'h0F and zero_flag=0. enable=0 gives bus_out=0 (or Z with TRISTATE_BUS_EN).
- INC wrap: reg1=8'hFF, op=INC -> reg1=8'h00, carry=1, zero=1. A second INC -> reg1=8'h01, carry=0, zero=0.
- DEC borrow: reg3=8'h00, op=DEC -> 8'hFF, carry=1, zero=0.
- Shifts: reg0=8'h81, SHL -> 8'h02, carry=1. Then SHR -> 8'h01, carry=0. Then SHR -> 8'h00, carry=1, zero=1.
- MOV and same-cycle read: reg2=8'hA5, op=MOV wr_sel=1 rd_sel=2 -> reg1=8'hA5, carry=0. Concurrently LOAD 8'h3C into reg1 with enable=1, rd_sel=1 -> bus_out shows 8'hA5 in the write cycle and 8'h3C after the edge.

Source files
------------

// File: rtl/reg_bank_alu.sv
// reg_bank_alu: bank of NUM_REGS x WIDTH registers with per-cycle ALU ops and registered zero/carry flags.
// Optional macro TRISTATE_BUS_EN: bus_out goes high-impedance instead of 0 when enable is low.
module reg_bank_alu #(
    parameter  int WIDTH    = 8,
    parameter  int NUM_REGS = 4,
    localparam int SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       op,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in_bus,
    output logic [WIDTH-1:0] bus_out,
    output logic             zero_flag,
    output logic             carry_flag
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_CLR  = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_MOV  = 3'd7
    } op_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic             zero_q;
    logic             carry_q;

    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] wr_cur;
    logic             wr_hit;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             do_wr;

    // Select decode by comparison so out-of-range indices simply match nothing.
    always_comb begin
        rd_val = '0;
        wr_cur = '0;
        wr_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_val = regs_q[i];
            end
            if (wr_sel == SEL_W'(i)) begin
                wr_cur = regs_q[i];
                wr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        res_d   = wr_cur;
        carry_d = carry_q;
        case (op_e'(op))
            OP_NOP: begin
                res_d   = wr_cur;
                carry_d = carry_q;
            end
            OP_LOAD: begin
                res_d   = data_in_bus;
                carry_d = 1'b0;
            end
            OP_CLR: begin
                res_d   = '0;
                carry_d = 1'b0;
            end
            OP_INC: begin
                res_d   = wr_cur + WIDTH'(1);
                carry_d = &wr_cur;
            end
            OP_DEC: begin
                res_d   = wr_cur - WIDTH'(1);
                carry_d = ~|wr_cur;
            end
            OP_SHL: begin
                res_d   = {wr_cur[WIDTH-2:0], 1'b0};
                carry_d = wr_cur[WIDTH-1];
            end
            OP_SHR: begin
                res_d   = {1'b0, wr_cur[WIDTH-1:1]};
                carry_d = wr_cur[0];
            end
            OP_MOV: begin
                res_d   = rd_val;
                carry_d = 1'b0;
            end
            default: begin
                res_d   = wr_cur;
                carry_d = carry_q;
            end
        endcase
    end

    assign do_wr = wr_hit && (op_e'(op) != OP_NOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (do_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel == SEL_W'(i)) begin
                    regs_q[i] <= res_d;
                end
            end
            zero_q  <= (res_d == '0);
            carry_q <= carry_d;
        end
    end

    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;

`ifdef TRISTATE_BUS_EN
    assign bus_out = enable ? rd_val : 'z;
`else
    assign bus_out = enable ? rd_val : '0;
`endif

endmodule

// File: tb/tb_reg_bank_alu.sv
// Bench for reg_bank_alu: a 4-register and a 3-register instance share stimulus and are
// compared every cycle against an arithmetic model of the register bank.
module tb_reg_bank_alu;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;
    logic       enable;
    logic [7:0] data_in_bus;

    logic [7:0] bus_out4, bus_out3;
    logic       zf4, cf4, zf3, cf3;

    int checks = 0;
    int errors = 0;

    // Model state: bank 0 has 4 registers, bank 1 has 3.
    int         nregs [2] = '{4, 3};
    logic [7:0] m_regs [2][4];
    logic       m_z [2];
    logic       m_c [2];

    reg_bank_alu #(.WIDTH(8), .NUM_REGS(4)) dut4 (
        .clk(clk), .rst(rst), .op(op), .wr_sel(wr_sel), .rd_sel(rd_sel),
        .enable(enable), .data_in_bus(data_in_bus), .bus_out(bus_out4),
        .zero_flag(zf4), .carry_flag(cf4)
    );

    reg_bank_alu #(.WIDTH(8), .NUM_REGS(3)) dut3 (
        .clk(clk), .rst(rst), .op(op), .wr_sel(wr_sel), .rd_sel(rd_sel),
        .enable(enable), .data_in_bus(data_in_bus), .bus_out(bus_out3),
        .zero_flag(zf3), .carry_flag(cf3)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] disabled_val();
`ifdef TRISTATE_BUS_EN
        return 8'bz;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] model_read(input int b, input int idx, input logic en);
        if (!en) return disabled_val();
        if (idx >= nregs[b]) return 8'h00;
        return m_regs[b][idx];
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) m_regs[b][i] = 8'h00;
            m_z[b] = 1'b0;
            m_c[b] = 1'b0;
        end
    endtask

    task automatic model_apply(input int b, input int o, input int wr, input int rd, input int data);
        int md, r, v, c, src;
        md = 1 << W;
        if (o == 0 || wr >= nregs[b]) return;
        src = (rd < nregs[b]) ? int'(m_regs[b][rd]) : 0;
        r   = int'(m_regs[b][wr]);
        v   = r;
        c   = 0;
        case (o)
            1: begin v = data;                c = 0;                     end
            2: begin v = 0;                   c = 0;                     end
            3: begin v = (r + 1) % md;        c = (r == md - 1) ? 1 : 0; end
            4: begin v = (r + md - 1) % md;   c = (r == 0) ? 1 : 0;      end
            5: begin v = (r * 2) % md;        c = r / (md / 2);          end
            6: begin v = r / 2;               c = r % 2;                 end
            default: begin v = src;           c = 0;                     end
        endcase
        m_regs[b][wr] = 8'(v);
        m_z[b]        = (v == 0);
        m_c[b]        = (c != 0);
    endtask

    // Drive one operation, let the edge happen, then advance the model.
    task automatic step(input int o, input int wr, input int rd, input logic en, input int data);
        op          = 3'(o);
        wr_sel      = 2'(wr);
        rd_sel      = 2'(rd);
        enable      = en;
        data_in_bus = 8'(data);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int b = 0; b < 2; b++) model_apply(b, o, wr, rd, data);
        end
    endtask

    task automatic peek(input string nm, input int rd, input logic [7:0] ev, input logic ez, input logic ec);
        op     = 3'd0;
        rd_sel = 2'(rd);
        enable = 1'b1;
        #1;
        check({nm, "_val"},   bus_out4, ev);
        check({nm, "_zero"},  8'(zf4),  8'(ez));
        check({nm, "_carry"}, 8'(cf4),  8'(ec));
    endtask

    task automatic mid_cycle_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #2;
        rst = 1'b1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("bus4",   bus_out4, model_read(0, int'(rd_sel), enable));
        check("zero4",  8'(zf4),  8'(m_z[0]));
        check("carry4", 8'(cf4),  8'(m_c[0]));
        check("bus3",   bus_out3, model_read(1, int'(rd_sel), enable));
        check("zero3",  8'(zf3),  8'(m_z[1]));
        check("carry3", 8'(cf3),  8'(m_c[1]));
    end

    initial begin
        model_reset();
        rst = 1'b0; op = 3'd0; wr_sel = 2'd0; rd_sel = 2'd0; enable = 1'b1; data_in_bus = 8'h00;
        #1;
        check("reset_bus",   bus_out4, 8'h00);
        check("reset_zero",  8'(zf4),  8'h00);
        check("reset_carry", 8'(cf4),  8'h00);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Async reset mid-cycle after loading reg0.
        step(1, 0, 0, 1'b1, 8'h5A);
        peek("load_5a", 0, 8'h5A, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        model_reset();
        peek("async_rst", 0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b1;

        // LOAD then read, with output enable toggled.
        step(1, 2, 0, 1'b0, 8'h0F);
        peek("load_0f", 2, 8'h0F, 1'b0, 1'b0);
        enable = 1'b0;
        #1;
        check("disabled_bus", bus_out4, disabled_val());

        // INC wrap.
        step(1, 1, 0, 1'b0, 8'hFF);
        step(3, 1, 0, 1'b0, 0);
        peek("inc_wrap", 1, 8'h00, 1'b1, 1'b1);
        step(3, 1, 0, 1'b0, 0);
        peek("inc_again", 1, 8'h01, 1'b0, 1'b0);

        // DEC borrow; reg3 is out of range for the 3-register bank.
        step(1, 3, 0, 1'b0, 8'h00);
        step(4, 3, 0, 1'b0, 0);
        peek("dec_borrow", 3, 8'hFF, 1'b0, 1'b1);

        // Shifts.
        step(1, 0, 0, 1'b0, 8'h81);
        step(5, 0, 0, 1'b0, 0);
        peek("shl", 0, 8'h02, 1'b0, 1'b1);
        step(6, 0, 0, 1'b0, 0);
        peek("shr1", 0, 8'h01, 1'b0, 1'b0);
        step(6, 0, 0, 1'b0, 0);
        peek("shr2", 0, 8'h00, 1'b1, 1'b1);

        // MOV and same-cycle read of the written register.
        step(1, 2, 0, 1'b0, 8'hA5);
        step(7, 1, 2, 1'b0, 0);
        peek("mov", 1, 8'hA5, 1'b0, 1'b0);
        op = 3'd1; wr_sel = 2'd1; rd_sel = 2'd1; enable = 1'b1; data_in_bus = 8'h3C;
        #1;
        check("same_cycle_old", bus_out4, 8'hA5);
        @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) model_apply(b, 1, 1, 1, 8'h3C);
        check("same_cycle_new", bus_out4, 8'h3C);

        // Out-of-range read in the 3-register bank, and MOV from it.
        rd_sel = 2'd3;
        op = 3'd0;
        #1;
        check("oor_read3", bus_out3, 8'h00);
        step(7, 0, 3, 1'b1, 0);
        check("oor_mov3_zero", 8'(zf3), 8'h01);
        check("mov_same_idx_pre", bus_out4, 8'hFF);
        step(7, 2, 2, 1'b1, 0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                mid_cycle_reset();
            end else begin
                step(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 255)));
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
